regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised successor to the 4-bit x 16 datapath register file. It provides:
  - two registered read ports, with an immediate select on port 2;
  - one gated write port, with a hard-wired zero register and overflow suppression;
  - a sequential bulk-clear engine;
  - a write-drop status pulse.
- Sits between instruction decode / control and the ALU operand inputs. The ALU result returns on the write port.

Parameters:
- DATA_W, 4: register and data width in bits.
- ADDR_W, 4: register address width. Depth is 2**ADDR_W (local, derived). Instruction width is 3*ADDR_W (local, derived).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- reg_write  in  1  write enable.
- reg_store  in  1  register-store qualifier; a write needs reg_write and reg_store.
- alu_src  in  1  0: port 2 reads a register; 1: port 2 takes the immediate.
- overflow  in  1  ALU overflow flag; suppresses the write.
- instruction  in  3*ADDR_W  fields:
  - [3A-1:2A] rs1 address;
  - [2A-1:A] rs2 address or immediate;
  - [A-1:0] rd address.
- write_data  in  DATA_W  data to write to rd.
- clear_req  in  1  single-cycle request to zero the whole file.
- busy  out  1  high while the clear engine runs.
- reg_out1  out  DATA_W  registered operand 1.
- reg_out2  out  DATA_W  registered operand 2.
- write_drop  out  1  registered one-cycle pulse: a requested write was discarded.

Behaviour:
- Reset (async, rst=1):
  - all registers 0, reg_out1=0, reg_out2=0;
  - busy=0, write_drop=0, FSM in IDLE, clear counter 0.
  - Applies immediately, including mid-clear; the clear is abandoned, which is harmless because the array is already zeroed.
- Read latency is 1 cycle. At each edge:
  - reg_out1 <= reg[rs1].
  - reg_out2 <= reg[rs2] when alu_src=0.
  - reg_out2 <= immediate zero-extended to DATA_W when alu_src=1. If DATA_W < ADDR_W, the immediate is truncated to its low DATA_W bits.
  - Reads of address 0 always return 0.
- Write commit condition, evaluated at the edge: reg_write & reg_store & (rd != 0) & ~overflow & (state == IDLE). On commit, reg[rd] <= write_data.
- Read/write collision on the same edge, FORWARD_EN undefined: a read returns the pre-write value.
- write_drop is set on the next edge when reg_write & reg_store is high but the commit condition is false. Causes: rd=0, overflow=1, or busy. Otherwise write_drop is 0.
- Clear FSM:
  - IDLE: busy=0. clear_req=1 moves to CLEAR, with counter <= 1 and busy <= 1 on the same edge.
  - CLEAR: on each edge reg[counter] <= 0 and counter increments. On the edge that clears address 2**ADDR_W-1, the FSM returns to IDLE and busy <= 0.
  - A clear takes 2**ADDR_W-1 cycles; register 0 is skipped.
  - clear_req during CLEAR is ignored, with no restart and no queueing.
  - Reads stay active during CLEAR and return the current array contents.
  - Writes during CLEAR are dropped and flagged via write_drop.
- clear_req and a valid write on the same IDLE edge: the write commits, and the clear starts on the same edge, so the written register is cleared later by the sweep.
- The counter is ADDR_W bits and does not wrap past the last address; the FSM exits first.

Optional Feature:
- Macro: REGFILE_FORWARD_EN.
- Defined: write-first bypass.
  - If a write commits on an edge and rs1 == rd, reg_out1 <= write_data.
  - If alu_src=0 and rs2 == rd, reg_out2 <= write_data.
  - During CLEAR, a read of the address being cleared on that edge returns 0.
  - Address 0 still reads 0.
- Undefined: reads always return the pre-edge array contents, with no bypass logic.

Test Plan:
- Reset:
  - Assert rst mid-cycle -> reg_out1, reg_out2, busy and write_drop go to 0 immediately.
  - After release, reading every address -> 0.
- Write then read:
  - Write 4'hA to r3, then rs1=3, rs2=3, alu_src=0 -> one cycle later reg_out1=reg_out2=4'hA.
  - With alu_src=1 and field=4'h7 -> reg_out2=4'h7.
- Suppression:
  - Write 4'h5 with rd=0 -> r0 still reads 0 and write_drop=1 for one cycle.
  - Write 4'h5 to r2 with overflow=1 -> r2 unchanged and write_drop=1.
- Clear:
  - Load r1..r15 with nonzero values, pulse clear_req -> busy high for exactly 15 cycles and all registers read 0 afterwards.
  - Write to r4 while busy -> dropped, with write_drop=1.
  - A second clear_req mid-sweep -> no change in busy length.
- Reset mid-clear: assert rst at cycle 7 of the sweep -> busy=0, state IDLE, all registers 0, and a new clear_req works normally.
- Collision: write 4'h9 to r6 with rs1=6 on the same edge. Old value 4'h2.
  - Without REGFILE_FORWARD_EN -> reg_out1=4'h2.
  - With it -> reg_out1=4'h9.

Source files
------------

// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
//
// Parametrised datapath register file. It has two registered read ports
// (port 2 can take an immediate instead), one gated write port, a hard-wired
// zero register, a sequential bulk-clear engine and a write-drop status pulse.
//
// Parameters
//   DATA_W  register / data width in bits
//   ADDR_W  register address width; depth = 2**ADDR_W, instruction = 3*ADDR_W
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   reg_write    write enable
//   reg_store    register-store qualifier (a write needs both enables)
//   alu_src      0: port 2 reads a register, 1: port 2 takes the immediate
//   overflow     ALU overflow flag, suppresses the write
//   instruction  {rs1, rs2/immediate, rd}
//   write_data   data to write to rd
//   clear_req    single-cycle request to zero the whole file
//   busy         high while the clear engine sweeps the file
//   reg_out1     registered operand 1
//   reg_out2     registered operand 2 (register or immediate)
//   write_drop   one-cycle pulse: a requested write was discarded
//
// Build option
//   REGFILE_FORWARD_EN  when defined, reads are write-first: a committing write
//                       and the address being swept by the clear engine are
//                       visible on the read ports in the same cycle. When
//                       undefined, reads return the pre-edge array contents.
// -----------------------------------------------------------------------------
module regfile_param #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_write,
  input  logic                  reg_store,
  input  logic                  alu_src,
  input  logic                  overflow,
  input  logic [3*ADDR_W-1:0]   instruction,
  input  logic [DATA_W-1:0]     write_data,
  input  logic                  clear_req,
  output logic                  busy,
  output logic [DATA_W-1:0]     reg_out1,
  output logic [DATA_W-1:0]     reg_out2,
  output logic                  write_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [ADDR_W-1:0]   w_clr_cnt_next;

  logic [DATA_W-1:0]   r_regs [DEPTH];
  logic [DATA_W-1:0]   r_out1;
  logic [DATA_W-1:0]   r_out2;
  logic                r_write_drop;

  logic [ADDR_W-1:0]   w_rs1;
  logic [ADDR_W-1:0]   w_rs2;
  logic [ADDR_W-1:0]   w_rd;
  logic                w_wr_req;
  logic                w_wr_commit;
  logic                w_clearing;
  logic                w_clear_last;
  logic [DATA_W+ADDR_W-1:0] w_imm_wide;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_rd1_data;
  logic [DATA_W-1:0]   w_rd2_data;

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  assign w_rs1 = instruction[3*ADDR_W-1:2*ADDR_W];
  assign w_rs2 = instruction[2*ADDR_W-1:ADDR_W];
  assign w_rd  = instruction[ADDR_W-1:0];

  // Zero-extend into a vector wide enough for either case, then keep the low
  // DATA_W bits: this extends when DATA_W > ADDR_W and truncates otherwise,
  // without a zero-width replication when the widths match.
  assign w_imm_wide = {{DATA_W{1'b0}}, w_rs2};
  assign w_imm      = w_imm_wide[DATA_W-1:0];

  assign w_clearing   = (r_state == S_CLEAR);
  assign w_clear_last = (r_clr_cnt == ADDR_W'(DEPTH - 1));

  // The write port is closed for the whole sweep so a sweep write and a
  // data write never target the array on the same edge.
  assign w_wr_req    = reg_write & reg_store;
  assign w_wr_commit = w_wr_req & (w_rd != '0) & ~overflow & ~w_clearing;

  // ---------------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_cnt <= w_clr_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    case (r_state)
      S_IDLE: begin
        // Register 0 is hard-wired, so the sweep starts at address 1.
        if (clear_req) begin
          w_state_next   = S_CLEAR;
          w_clr_cnt_next = ADDR_W'(1);
        end
      end
      S_CLEAR: begin
        // Leave on the edge that clears the last address; the counter is
        // parked at 0 instead of wrapping. clear_req is ignored here.
        if (w_clear_last) begin
          w_state_next   = S_IDLE;
          w_clr_cnt_next = '0;
        end else begin
          w_clr_cnt_next = r_clr_cnt + ADDR_W'(1);
        end
      end
      default: begin
        w_state_next   = S_IDLE;
        w_clr_cnt_next = '0;
      end
    endcase
  end

  assign busy = w_clearing;

  // ---------------------------------------------------------------------------
  // Register array. Address 0 is never written (rd != 0 on commit and the
  // sweep starts at 1), so it stays at its reset value of zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_wr_commit) begin
        r_regs[w_rd] <= write_data;
      end
      if (w_clearing) begin
        r_regs[r_clr_cnt] <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rd1_data = r_regs[w_rs1];
`ifdef REGFILE_FORWARD_EN
    // Commit and sweep are mutually exclusive, so at most one bypass applies.
    if (w_wr_commit && (w_rs1 == w_rd)) begin
      w_rd1_data = write_data;
    end
    if (w_clearing && (w_rs1 == r_clr_cnt)) begin
      w_rd1_data = '0;
    end
`endif
    if (w_rs1 == '0) begin
      w_rd1_data = '0;
    end
  end

  always_comb begin
    w_rd2_data = r_regs[w_rs2];
`ifdef REGFILE_FORWARD_EN
    if (w_wr_commit && (w_rs2 == w_rd)) begin
      w_rd2_data = write_data;
    end
    if (w_clearing && (w_rs2 == r_clr_cnt)) begin
      w_rd2_data = '0;
    end
`endif
    if (w_rs2 == '0) begin
      w_rd2_data = '0;
    end
    if (alu_src) begin
      w_rd2_data = w_imm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out1       <= '0;
      r_out2       <= '0;
      r_write_drop <= 1'b0;
    end else begin
      r_out1       <= w_rd1_data;
      r_out2       <= w_rd2_data;
      // A requested write that does not commit: rd = 0, overflow, or sweep.
      r_write_drop <= w_wr_req & ~w_wr_commit;
    end
  end

  assign reg_out1   = r_out1;
  assign reg_out2   = r_out2;
  assign write_drop = r_write_drop;

endmodule

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param
//
// Self-checking bench for regfile_param (DATA_W=4, ADDR_W=4). A behavioural
// model (plain array plus a "sweep in progress / next address" pair) predicts
// the outputs for every clock edge; the DUT is compared against it after each
// edge. Directed scenarios add hand-computed literal expectations, then a
// randomized phase runs against the model.
// -----------------------------------------------------------------------------
module tb_regfile_param;

  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 2 ** AW;

  logic              clk;
  logic              rst;
  logic              reg_write;
  logic              reg_store;
  logic              alu_src;
  logic              overflow;
  logic [3*AW-1:0]   instruction;
  logic [DW-1:0]     write_data;
  logic              clear_req;
  logic              busy;
  logic [DW-1:0]     reg_out1;
  logic [DW-1:0]     reg_out2;
  logic              write_drop;

  regfile_param #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .reg_write   (reg_write),
    .reg_store   (reg_store),
    .alu_src     (alu_src),
    .overflow    (overflow),
    .instruction (instruction),
    .write_data  (write_data),
    .clear_req   (clear_req),
    .busy        (busy),
    .reg_out1    (reg_out1),
    .reg_out2    (reg_out2),
    .write_drop  (write_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Counters and reporting
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;
  int txn    = 0;
  bit verbose = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_sweeping;
  int            m_sweep_addr;
  logic [DW-1:0] e_out1;
  logic [DW-1:0] e_out2;
  bit            e_drop;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_sweeping   = 1'b0;
    m_sweep_addr = 0;
    e_out1 = '0;
    e_out2 = '0;
    e_drop = 1'b0;
  endtask

  function automatic logic [DW-1:0] model_read(input int a, input bit commit, input int rd,
                                               input logic [DW-1:0] wd);
    if (a == 0) return '0;
`ifdef REGFILE_FORWARD_EN
    if (commit && a == rd) return wd;
    if (m_sweeping && a == m_sweep_addr) return '0;
`endif
    return m_mem[a];
  endfunction

  // Predict the effect of the coming rising edge from the inputs now applied.
  task automatic model_edge();
    int rs1, rs2, rd;
    bit req, commit;
    if (rst) begin
      model_reset();
      return;
    end
    rs1 = int'(instruction[3*AW-1:2*AW]);
    rs2 = int'(instruction[2*AW-1:AW]);
    rd  = int'(instruction[AW-1:0]);
    req    = reg_write && reg_store;
    commit = req && (rd != 0) && !overflow && !m_sweeping;
    e_out1 = model_read(rs1, commit, rd, write_data);
    if (alu_src) e_out2 = DW'(rs2 % (1 << DW));
    else         e_out2 = model_read(rs2, commit, rd, write_data);
    e_drop = req && !commit;
    if (commit) m_mem[rd] = write_data;
    if (m_sweeping) begin
      m_mem[m_sweep_addr] = '0;
      m_sweep_addr++;
      if (m_sweep_addr == DEPTH) m_sweeping = 1'b0;
    end else if (clear_req) begin
      m_sweeping   = 1'b1;
      m_sweep_addr = 1;
    end
  endtask

  // One clock cycle: predict, let the edge happen, compare on the falling edge.
  task automatic step();
    model_edge();
    @(negedge clk);
    txn++;
    if (verbose)
      $display("txn %0d: rst=%0b we=%0b st=%0b ovf=%0b src=%0b instr=%03h wd=%0h clr=%0b -> out1=%0h out2=%0h busy=%0b drop=%0b",
               txn, rst, reg_write, reg_store, overflow, alu_src, instruction, write_data,
               clear_req, reg_out1, reg_out2, busy, write_drop);
    check("reg_out1", 32'(reg_out1), 32'(e_out1));
    check("reg_out2", 32'(reg_out2), 32'(e_out2));
    check("busy", 32'(busy), 32'(m_sweeping));
    check("write_drop", 32'(write_drop), 32'(e_drop));
  endtask

  task automatic set_instr(input int rs1, input int rs2, input int rd);
    instruction = {AW'(rs1), AW'(rs2), AW'(rd)};
  endtask

  task automatic idle_inputs();
    reg_write  = 1'b0;
    reg_store  = 1'b0;
    alu_src    = 1'b0;
    overflow   = 1'b0;
    clear_req  = 1'b0;
    write_data = '0;
    set_instr(0, 0, 0);
  endtask

  task automatic do_write(input int rd, input int val, input int rs1);
    reg_write  = 1'b1;
    reg_store  = 1'b1;
    write_data = DW'(val);
    set_instr(rs1, 0, rd);
    step();
    reg_write  = 1'b0;
    reg_store  = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      set_instr(a, DEPTH - 1 - a, 0);
      step();
      check({tag, "_out1"}, 32'(reg_out1), 32'h0);
      check({tag, "_out2"}, 32'(reg_out2), 32'h0);
    end
  endtask

  // Asynchronous reset asserted between clock edges, outputs checked at once.
  task automatic async_reset_pulse(input string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check({tag, "_out1"}, 32'(reg_out1), 32'h0);
    check({tag, "_out2"}, 32'(reg_out2), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_drop"}, 32'(write_drop), 32'h0);
    step();
    rst = 1'b0;
  endtask

  // Counts cycles with busy high after the clear_req edge; bounded.
  task automatic run_clear(input string tag, input bit poke);
    int n;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    n = busy ? 1 : 0;
    for (int k = 0; k < 40 && busy; k++) begin
      clear_req = poke && (k == 4);
      if (poke && k == 6) begin
        reg_write = 1'b1; reg_store = 1'b1; write_data = 4'hF; set_instr(4, 4, 4);
      end else begin
        reg_write = 1'b0; reg_store = 1'b0; set_instr(k % DEPTH, 0, 0);
      end
      step();
      if (poke && k == 6) check({tag, "_drop_busy"}, 32'(write_drop), 32'h1);
      if (busy) n++;
    end
    idle_inputs();
    check({tag, "_busy_len"}, 32'(n), 32'd15);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    step();
    step();
    check("reset_out1", 32'(reg_out1), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    read_all_zero("post_reset");

    // Write then read, register and immediate operand 2.
    do_write(3, 'hA, 0);
    set_instr(3, 3, 0);
    step();
    check("wr_rd_out1", 32'(reg_out1), 32'hA);
    check("wr_rd_out2", 32'(reg_out2), 32'hA);
    alu_src = 1'b1;
    set_instr(3, 7, 0);
    step();
    check("imm_out2", 32'(reg_out2), 32'h7);
    alu_src = 1'b0;

    // Write to r0 is dropped and flagged for one cycle.
    do_write(0, 'h5, 0);
    check("r0_drop", 32'(write_drop), 32'h1);
    set_instr(0, 0, 0);
    step();
    check("r0_drop_clear", 32'(write_drop), 32'h0);
    check("r0_reads_zero", 32'(reg_out1), 32'h0);

    // Overflow suppresses the write.
    do_write(2, 'hC, 0);
    overflow = 1'b1;
    do_write(2, 'h5, 0);
    check("ovf_drop", 32'(write_drop), 32'h1);
    overflow = 1'b0;
    set_instr(2, 2, 0);
    step();
    check("ovf_keep", 32'(reg_out1), 32'hC);

    // Same-edge read/write collision on r6.
    do_write(6, 'h2, 0);
    do_write(6, 'h9, 6);
`ifdef REGFILE_FORWARD_EN
    check("collision", 32'(reg_out1), 32'h9);
`else
    check("collision", 32'(reg_out1), 32'h2);
`endif
    set_instr(6, 0, 0);
    step();
    check("collision_after", 32'(reg_out1), 32'h9);

    // Mid-cycle reset with a drop pulse and nonzero operands pending.
    do_write(0, 'h3, 3);
    async_reset_pulse("midcycle_rst");
    read_all_zero("after_rst");

    // Bulk clear: load r1..r15, sweep, poke clear_req and a write mid-sweep.
    for (int i = 1; i < DEPTH; i++) do_write(i, i, 0);
    set_instr(15, 1, 0);
    step();
    check("loaded_r15", 32'(reg_out1), 32'hF);
    run_clear("clear", 1'b1);
    read_all_zero("after_clear");

    // Reset on cycle 7 of a sweep, then a fresh clear works normally.
    for (int i = 1; i < DEPTH; i++) do_write(i, 16 - i, 0);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (6) step();
    check("sweep_running", 32'(busy), 32'h1);
    async_reset_pulse("rst_midclear");
    read_all_zero("after_rst_clear");
    do_write(5, 'h3, 0);
    run_clear("clear2", 1'b0);
    read_all_zero("after_clear2");

    // Randomized phase.
    verbose = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reg_write   = ($urandom_range(0, 3) != 0);
      reg_store   = ($urandom_range(0, 3) != 0);
      alu_src     = $urandom_range(0, 1) == 1;
      overflow    = ($urandom_range(0, 7) == 0);
      clear_req   = ($urandom_range(0, 29) == 0);
      instruction = (3*AW)'($urandom);
      write_data  = DW'($urandom);
      if ($urandom_range(0, 499) == 0) async_reset_pulse("rand_rst");
      else step();
    end
    $display("random phase: %0d transactions", 3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
